// File: rtl/vec_sequencer.sv
// Element sequencer for vector instructions: stalls fetch, walks the lane index
// one write per cycle through the scalar ALU, then pulses Done for one cycle.
module vec_sequencer #(
  parameter int NLANES = 8,
  parameter int IDXW   = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic [IDXW:0]   Len,
  input  logic [3:0]      Op,
  input  logic            Kill,
  output logic            Stall,
  output logic            Busy,
  output logic [IDXW-1:0] ElemIdx,
  output logic [3:0]      ElemALUControl,
  output logic            ElemWrite,
  output logic            Done
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [IDXW:0] NLANES_W = (IDXW+1)'(NLANES);

  state_t          state_reg, state_next;
  logic [IDXW-1:0] idx_reg, idx_next;
  logic [IDXW-1:0] last_reg, last_next;
  logic [3:0]      op_reg, op_next;

  logic [IDXW:0]   len_eff;
  logic [IDXW:0]   last_full;

  // Over-long requests are clamped so the index can never run past the last lane.
  assign len_eff   = (Len > NLANES_W) ? NLANES_W : Len;
  assign last_full = len_eff - (IDXW+1)'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      last_reg  <= '0;
      op_reg    <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      last_reg  <= last_next;
      op_reg    <= op_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    last_next      = last_reg;
    op_next        = op_reg;
    Stall          = 1'b0;
    Busy           = (state_reg != IDLE);
    ElemIdx        = '0;
    ElemALUControl = '0;
    ElemWrite      = 1'b0;
    Done           = 1'b0;

    case (state_reg)
      IDLE: begin
        // Stall in the accepting cycle so the PC never moves past the instruction.
        if (Start && (Len != '0)) begin
          Stall      = 1'b1;
          state_next = RUN;
          op_next    = Op;
          idx_next   = '0;
          last_next  = last_full[IDXW-1:0];
        end
      end
      RUN: begin
        Stall          = 1'b1;
        ElemIdx        = idx_reg;
        ElemALUControl = op_reg;
        ElemWrite      = ~Kill;
        if (idx_reg != last_reg) begin
          idx_next = idx_reg + IDXW'(1);
        end else begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        // Start is ignored here: it still belongs to the instruction just completed.
        Done       = ~Kill;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (Kill) begin
      state_next = IDLE;
      idx_next   = '0;
    end
  end

endmodule
